// File: rtl/receptor_pedido_serial.sv
// UART request receiver (8N1, or 8E1 with PARIDADE_PAR_EN) with valid/ready output.
// Drops malformed frames and illegal requests, pulsing the matching error flag.
module receptor_pedido_serial #(
    parameter int DIVISOR  = 434,
    parameter int MEIO_BIT = DIVISOR / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       pedido_pronto,
    output logic       pedido_valido,
    output logic [1:0] pedido_objeto,
    output logic [1:0] pedido_destino,
    output logic [1:0] pedido_origem,
    output logic       erro_quadro,
    output logic       erro_pedido,
    output logic       sobrescrita,
    output logic       recebendo,
    output logic [7:0] ultimo_byte_db
);

    localparam int CW = $clog2(DIVISOR);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
`ifdef PARIDADE_PAR_EN
        PARIDADE,
`endif
        PARADA,
        ESPERA_ALTO
    } estado_t;

    estado_t       estado;
    logic          rx_m;
    logic          rs;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          fim_bit;
    logic          fim_meio;
    logic          byte_ok;
    logic          livre;

    assign fim_bit  = (cnt == CW'(DIVISOR - 1));
    assign fim_meio = (cnt == CW'(MEIO_BIT - 1));
    assign byte_ok  = (shreg[7:6] == 2'b00) && (shreg[1:0] != shreg[3:2]);
    // Output slot can take a new request if empty or being drained this cycle
    assign livre    = !pedido_valido || pedido_pronto;
    assign recebendo = (estado != OCIOSO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rs   <= 1'b1;
        end else begin
            rx_m <= rx;
            rs   <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado         <= OCIOSO;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            pedido_valido  <= 1'b0;
            pedido_objeto  <= '0;
            pedido_destino <= '0;
            pedido_origem  <= '0;
            erro_quadro    <= 1'b0;
            erro_pedido    <= 1'b0;
            sobrescrita    <= 1'b0;
            ultimo_byte_db <= '0;
        end else begin
            erro_quadro <= 1'b0;
            erro_pedido <= 1'b0;
            sobrescrita <= 1'b0;
            if (pedido_valido && pedido_pronto)
                pedido_valido <= 1'b0;

            unique case (estado)
                OCIOSO: begin
                    cnt <= '0;
                    if (!rs)
                        estado <= INICIO;
                end
                INICIO: begin
                    if (fim_meio) begin
                        cnt <= '0;
                        idx <= '0;
                        estado <= rs ? OCIOSO : DADOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        cnt   <= '0;
                        shreg <= {rs, shreg[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) begin
`ifdef PARIDADE_PAR_EN
                            estado <= PARIDADE;
`else
                            estado <= PARADA;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef PARIDADE_PAR_EN
                PARIDADE: begin
                    if (fim_bit) begin
                        cnt <= '0;
                        if (^{shreg, rs}) begin
                            erro_quadro <= 1'b1;
                            estado      <= OCIOSO;
                        end else begin
                            estado <= PARADA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                PARADA: begin
                    if (fim_bit) begin
                        cnt <= '0;
                        if (rs) begin
                            estado         <= OCIOSO;
                            ultimo_byte_db <= shreg;
                            if (!byte_ok) begin
                                erro_pedido <= 1'b1;
                            end else if (livre) begin
                                pedido_valido  <= 1'b1;
                                pedido_objeto  <= shreg[5:4];
                                pedido_destino <= shreg[3:2];
                                pedido_origem  <= shreg[1:0];
                            end else begin
                                sobrescrita <= 1'b1;
                            end
                        end else begin
                            erro_quadro <= 1'b1;
                            estado      <= ESPERA_ALTO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ESPERA_ALTO: begin
                    cnt <= '0;
                    if (rs)
                        estado <= OCIOSO;
                end
                default: begin
                    cnt    <= '0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_pedido_serial.sv
// Scoreboard bench for receptor_pedido_serial: directed UART frames at 435 cycles/bit.
// Define PARIDADE_PAR_EN for both RTL and bench to exercise the 8E1 frame.
module tb_receptor_pedido_serial;

    localparam int BIT = 435;

    typedef struct packed {
        logic [1:0] obj;
        logic [1:0] dest;
        logic [1:0] orig;
    } req_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       pedido_pronto = 1'b1;
    logic       pedido_valido;
    logic [1:0] pedido_objeto;
    logic [1:0] pedido_destino;
    logic [1:0] pedido_origem;
    logic       erro_quadro;
    logic       erro_pedido;
    logic       sobrescrita;
    logic       recebendo;
    logic [7:0] ultimo_byte_db;

    int checks = 0;
    int errors = 0;
    int n_eq = 0;
    int n_ep = 0;
    int n_sob = 0;
    req_t esperado[$];

    receptor_pedido_serial dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .pedido_pronto(pedido_pronto),
        .pedido_valido(pedido_valido),
        .pedido_objeto(pedido_objeto),
        .pedido_destino(pedido_destino),
        .pedido_origem(pedido_origem),
        .erro_quadro(erro_quadro),
        .erro_pedido(erro_pedido),
        .sobrescrita(sobrescrita),
        .recebendo(recebendo),
        .ultimo_byte_db(ultimo_byte_db)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nome, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     nome, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stop);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
`ifdef PARIDADE_PAR_EN
        rx = par;
        tick(BIT);
`else
        if (par) tick(0);
`endif
        rx = stop;
        tick(BIT);
        if (stop) tick(20);
    endtask

    // Monitor: every transfer must match the oldest expected request
    always @(negedge clk) begin
        if (!reset) begin
            if (erro_quadro) n_eq++;
            if (erro_pedido) n_ep++;
            if (sobrescrita) n_sob++;
            if (pedido_valido && pedido_pronto) begin
                checks++;
                if (esperado.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_request: got %b%b%b, expected none",
                             pedido_objeto, pedido_destino, pedido_origem);
                end else begin
                    req_t e;
                    e = esperado.pop_front();
                    if ({pedido_objeto, pedido_destino, pedido_origem} != e) begin
                        errors++;
                        $display("FAIL request_fields: got %b_%b_%b, expected %b_%b_%b",
                                 pedido_objeto, pedido_destino, pedido_origem,
                                 e.obj, e.dest, e.orig);
                    end
                end
            end
        end
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(5);
        chk("reset_valido", pedido_valido, 0);
        chk("reset_campos", {pedido_objeto, pedido_destino, pedido_origem}, 0);
        chk("reset_erros", {erro_quadro, erro_pedido, sobrescrita}, 0);
        chk("reset_recebendo", recebendo, 0);
        chk("reset_db", ultimo_byte_db, 0);
        reset = 1'b0;
        tick(10);

        // Simple delivery with consumer always ready
        esperado.push_back('{2'b01, 2'b11, 2'b01});
        send_frame(8'h1D, 1'b0, 1'b1);
        chk("t1_db", ultimo_byte_db, 8'h1D);
        chk("t1_erros", n_eq + n_ep + n_sob, 0);
        chk("t1_entregue", esperado.size(), 0);

        // Overrun: first request held, second dropped
        pedido_pronto = 1'b0;
        esperado.push_back('{2'b01, 2'b11, 2'b10});
        send_frame(8'h1E, 1'b0, 1'b1);
        chk("t2_valido", pedido_valido, 1);
        send_frame(8'h17, 1'b0, 1'b1);
        chk("t2_sobrescrita", n_sob, 1);
        chk("t2_db", ultimo_byte_db, 8'h17);
        chk("t2_retido", {pedido_destino, pedido_origem}, 4'b1110);
        pedido_pronto = 1'b1;
        tick(1);
        pedido_pronto = 1'b0;
        tick(1);
        chk("t2_valido_caiu", pedido_valido, 0);
        chk("t2_campos", {pedido_objeto, pedido_destino, pedido_origem}, 6'b011110);
        chk("t2_entregue", esperado.size(), 0);
        pedido_pronto = 1'b1;

        // Illegal requests
        send_frame(8'h15, 1'b1, 1'b1);
        send_frame(8'hC6, 1'b0, 1'b1);
        chk("t3_erro_pedido", n_ep, 2);
        chk("t3_db", ultimo_byte_db, 8'hC6);
        chk("t3_outros", n_eq + n_sob, 1);

        // False start
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(600);
        chk("t4_falso_recebendo", recebendo, 0);
        chk("t4_falso_flags", n_eq * 100 + n_ep * 10 + n_sob, 21);

        // Framing error followed by a long break
        send_frame(8'h1D, 1'b0, 1'b0);
        rx = 1'b0;
        tick(5000);
        chk("t4_break_recebendo", recebendo, 1);
        chk("t4_erro_quadro", n_eq, 1);
        rx = 1'b1;
        tick(5);
        chk("t4_fim_recebendo", recebendo, 0);
        tick(600);
        chk("t4_erro_quadro_unico", n_eq, 1);
        chk("t4_outros", n_ep * 10 + n_sob, 21);

        // Reset during data bit 4, then a clean frame
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h1D >> i);
            tick(BIT);
        end
        rx = 1'b1;
        tick(BIT / 2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2 * BIT);
        chk("t5_sem_saida", pedido_valido, 0);
        chk("t5_recebendo", recebendo, 0);
        esperado.push_back('{2'b01, 2'b11, 2'b10});
        send_frame(8'h1E, 1'b0, 1'b1);
        chk("t5_db", ultimo_byte_db, 8'h1E);
        chk("t5_entregue", esperado.size(), 0);

`ifdef PARIDADE_PAR_EN
        esperado.push_back('{2'b01, 2'b11, 2'b01});
        send_frame(8'h1D, 1'b0, 1'b1);
        chk("t6_par_ok", esperado.size(), 0);
        send_frame(8'h1D, 1'b1, 1'b1);
        chk("t6_par_erro", n_eq, 2);
`endif

        tick(20);
        chk("final_fila_vazia", esperado.size(), 0);
        chk("final_flags", n_ep * 10 + n_sob, 21);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/receptor_pedido_serial.md
Name: receptor_pedido_serial

Overview:
- Upstream request-entry stage of smart_cargo.
- Receives 8N1 UART bytes on the RX line at 115200 baud (50 MHz clock).
- Decodes each byte into a cargo request: object, destination floor, origin floor.
- Presents the request through a valid/ready handshake to the request-queue writer, which stores it in the queue RAM.
- Malformed frames and illegal requests are dropped and flagged.

Parameters:
- DIVISOR, 434, clock cycles per bit (50 MHz / 115200); minimum 8.
- MEIO_BIT, DIVISOR/2 (217), cycles from the start-bit falling edge to the start-bit mid-point check.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- rx  in  1  serial line, idle high, asynchronous to clk
- pedido_pronto  in  1  consumer ready
- pedido_valido  out  1  request available
- pedido_objeto  out  2  byte bits [5:4]
- pedido_destino  out  2  byte bits [3:2], destination floor 0-3
- pedido_origem  out  2  byte bits [1:0], origin floor 0-3
- erro_quadro  out  1  one-cycle pulse: stop bit sampled low
- erro_pedido  out  1  one-cycle pulse: illegal request byte
- sobrescrita  out  1  one-cycle pulse: request lost because output still occupied
- recebendo  out  1  high while the FSM is not in OCIOSO
- ultimo_byte_db  out  8  last fully received byte, debug

Behaviour:
- Reset values: all outputs 0; ultimo_byte_db = 0; FSM in OCIOSO; rx synchroniser flops = 1.
- rx passes through a 2-flop synchroniser. All sampling uses the synchronised value rs.
- FSM states: OCIOSO, INICIO, DADOS, PARADA, ESPERA_ALTO.
  - OCIOSO: when rs = 0, clear the cycle counter and go to INICIO.
  - INICIO: after MEIO_BIT cycles, sample rs.
    - rs = 0: go to DADOS, clear counter and bit index.
    - rs = 1: false start; return to OCIOSO with no flag.
  - DADOS: every DIVISOR cycles, shift rs in LSB first. After bit 7, go to PARADA.
  - PARADA: after DIVISOR cycles, sample rs.
    - rs = 1: latch the byte into ultimo_byte_db, then validate; go to OCIOSO.
    - rs = 0: pulse erro_quadro, discard the byte, go to ESPERA_ALTO.
  - ESPERA_ALTO: stay until rs = 1, then go to OCIOSO. This prevents a break condition from producing repeated frames.
- Validation, done on the cycle the stop bit is sampled:
  - The byte is legal only if bits [7:6] = 00 and origem ≠ destino.
  - Illegal byte: pulse erro_pedido on the next cycle; outputs unchanged.
- Delivery: a legal byte produces the following on the cycle after the stop-bit sample:
  - pedido_valido = 1;
  - fields loaded from the byte.
- Handshake:
  - pedido_valido and the fields stay stable until a cycle with pedido_valido & pedido_pronto.
  - pedido_valido drops on the next cycle.
  - The consumer may hold pedido_pronto high permanently. A transfer then completes in the first cycle valid is high.
- Overrun: a legal byte completes while pedido_valido = 1 and no transfer happens that same cycle.
  - Pulse sobrescrita; the new request is dropped and the held one is kept.
  - If a transfer happens in that same cycle, the new request loads with no overrun.
- Reception continues independently of the handshake. rx is never back-pressured.
- Counter width is ceil(log2(DIVISOR)) bits. The counter clears on every state change.
- Reset mid-frame: the partial byte is discarded and any held request is cleared.
- Error pulses are mutually exclusive per frame and never coincide with a new pedido_valido rising.
- Latency from the start-bit falling edge on rx to pedido_valido = 2 (sync) + MEIO_BIT + 9·DIVISOR + 1 cycles, i.e. 4126 cycles at default parameters.

Optional Feature:
- Macro: PARIDADE_PAR_EN.
- Defined:
  - Frame is 8E1.
  - An extra PARIDADE state follows DADOS and samples the parity bit after DIVISOR cycles.
  - A parity mismatch (even parity over 8 data bits + parity bit) pulses erro_quadro and returns to OCIOSO. The stop bit is not waited for.
  - Latency grows by DIVISOR cycles.
- Not defined: 8N1 only; the PARIDADE state and its logic are absent.

Test Plan:
- Send 8'b00011101 at 435 cycles/bit, pedido_pronto = 1 → one pedido_valido pulse with objeto = 01, destino = 11, origem = 01; ultimo_byte_db = 8'h1D; no error pulses.
- Send 8'b00011110 with pedido_pronto = 0, then 8'b00010111 → first request held (destino = 11, origem = 10); second byte pulses sobrescrita. After pedido_pronto = 1 for one cycle, valid drops and the fields are still those of the first request.
- Send 8'b00010101 (origem = destino = 01), then 8'b11000110 → two erro_pedido pulses; pedido_valido stays 0.
- Drive rx low for 100 cycles, then high → back to OCIOSO with no flags and no output. Next, a frame with the stop bit forced low and rx then held low for 5000 cycles → exactly one erro_quadro, recebendo high until rx rises.
- Assert reset during data bit 4 of 8'h1D, then send 8'h1E → no output for the aborted frame; 8'h1E is delivered correctly.
- PARIDADE_PAR_EN defined: send 8'h1D with parity 0 → delivered. Send 8'h1D with parity 1 → erro_quadro, no pedido_valido.
